// File: rtl/parse_sign.sv
// parse_sign: scatters a packed signature into per-round verifier arrays, one round per cycle.
// Define PARSE_SIGN_CHK_EN to validate lc in CHECK and drive parse_err; otherwise lc is trusted.
module parse_sign #(
   parameter  int N_ROUND = 8,
   parameter  int N_CHAL  = 4,
   localparam int Z_W     = 4352,
   localparam int SIG_W   = 640 + (N_ROUND - N_CHAL) * 384 + N_CHAL * Z_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      parse_sign_start,
   input  logic [N_CHAL*5-1:0]       lc,
   input  logic [SIG_W-1:0]          sigma_i,
   output logic [255:0]              h_t_o,
   output logic [255:0]              salt_o,
   output logic [127:0]              seed_triangle_o,
   output logic [128*N_ROUND-1:0]    seed_star_o,
   output logic [256*N_ROUND-1:0]    Cv_o,
   output logic [1920*N_ROUND-1:0]   seed_o,
   output logic [128*N_ROUND-1:0]    masked_key_o,
   output logic [512*N_ROUND-1:0]    msgs_o,
   output logic [256*N_ROUND-1:0]    C_o,
   output logic [512*N_ROUND-1:0]    seed_lambda_o,
   output logic [1024*N_ROUND-1:0]   aux_triangle_o,
   output logic [N_ROUND-1:0]        in_lc_o,
   output logic                      parse_err,
   output logic                      parse_sign_end
);

   localparam int N_SEED = N_ROUND - N_CHAL;
   localparam int J_W    = $clog2(N_ROUND);
   localparam int C1_W   = $clog2(N_ROUND + 1);
   localparam int C2_W   = $clog2(N_CHAL + 1);

   // Only the per-round body of sigma is kept; h_t, salt and seed_triangle load straight to outputs.
   localparam int BODY_W   = SIG_W - 640;
   localparam int ISEED_HI = BODY_W - 1;
   localparam int CV_HI    = BODY_W - 1 - N_SEED * 128;
   localparam int Z_HI     = BODY_W - 1 - N_SEED * 384;

   localparam int SEED_W = 1920;
   localparam int MK_W   = 128;
   localparam int MSG_W  = 512;
   localparam int C_W    = 256;
   localparam int SL_W   = 512;
   localparam int AUX_W  = 1024;
   localparam int SL_LO   = AUX_W;
   localparam int C_LO    = SL_LO + SL_W;
   localparam int MSG_LO  = C_LO + C_W;
   localparam int MK_LO   = MSG_LO + MSG_W;
   localparam int SEED_LO = MK_LO + MK_W;

   typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

   state_t              state;
   logic [BODY_W-1:0]   body_r;
   logic [N_CHAL*5-1:0] lc_r;
   logic [J_W-1:0]      j;
   logic [C1_W-1:0]     c1;
   logic [C2_W-1:0]     c2;

   logic                hit;
   logic [127:0]        iseed_sel;
   logic [255:0]        cv_sel;
   logic [Z_W-1:0]      z_sel;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      hit = 1'b0;
      for (int k = 0; k < N_CHAL; k++)
         if (lc_r[(N_CHAL-1-k)*5 +: 5] == 5'(j)) hit = 1'b1;
   end

   // Out-of-range counters select nothing; the write side masks them as well.
   always_comb begin
      iseed_sel = '0;
      cv_sel    = '0;
      z_sel     = '0;
      for (int c = 0; c < N_SEED; c++)
         if (c1 == C1_W'(c)) begin
            iseed_sel = body_r[ISEED_HI - c*128 -: 128];
            cv_sel    = body_r[CV_HI - c*256 -: 256];
         end
      for (int c = 0; c < N_CHAL; c++)
         if (c2 == C2_W'(c)) z_sel = body_r[Z_HI - c*Z_W -: Z_W];
   end

`ifdef PARSE_SIGN_CHK_EN
   logic lc_ok;
   always_comb begin
      lc_ok = 1'b1;
      for (int k = 0; k < N_CHAL; k++) begin
         if (lc_r[(N_CHAL-1-k)*5 +: 5] >= 5'(N_ROUND)) lc_ok = 1'b0;
         for (int m = k + 1; m < N_CHAL; m++)
            if (lc_r[(N_CHAL-1-k)*5 +: 5] == lc_r[(N_CHAL-1-m)*5 +: 5]) lc_ok = 1'b0;
      end
   end
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the wide capture register is reset too, so nothing of a previous signature survives reset.
         state           <= IDLE;
         body_r          <= '0;
         lc_r            <= '0;
         j               <= '0;
         c1              <= '0;
         c2              <= '0;
         h_t_o           <= '0;
         salt_o          <= '0;
         seed_triangle_o <= '0;
         seed_star_o     <= '0;
         Cv_o            <= '0;
         seed_o          <= '0;
         masked_key_o    <= '0;
         msgs_o          <= '0;
         C_o             <= '0;
         seed_lambda_o   <= '0;
         aux_triangle_o  <= '0;
         in_lc_o         <= '0;
         parse_err       <= 1'b0;
         parse_sign_end  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (parse_sign_start && !parse_sign_end) begin
                  body_r          <= sigma_i[SIG_W-513 -: BODY_W];
                  lc_r            <= lc;
                  h_t_o           <= sigma_i[SIG_W-1 -: 256];
                  salt_o          <= sigma_i[SIG_W-257 -: 256];
                  seed_triangle_o <= sigma_i[127:0];
                  seed_star_o     <= '0;
                  Cv_o            <= '0;
                  seed_o          <= '0;
                  masked_key_o    <= '0;
                  msgs_o          <= '0;
                  C_o             <= '0;
                  seed_lambda_o   <= '0;
                  aux_triangle_o  <= '0;
                  in_lc_o         <= '0;
                  j               <= '0;
                  c1              <= '0;
                  c2              <= '0;
                  parse_err       <= 1'b0;
                  state           <= CHECK;
               end
            end

            CHECK: begin
`ifdef PARSE_SIGN_CHK_EN
               if (!lc_ok) begin
                  parse_err <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= SCAN;
               end
`else
               state <= SCAN;
`endif
            end

            SCAN: begin
               for (int r = 0; r < N_ROUND; r++) begin
                  if (j == J_W'(r)) begin
                     if (hit) begin
                        in_lc_o[N_ROUND-1-r] <= 1'b1;
                        if (c2 < C2_W'(N_CHAL)) begin
                           seed_o[(N_ROUND-1-r)*SEED_W +: SEED_W]       <= z_sel[SEED_LO +: SEED_W];
                           masked_key_o[(N_ROUND-1-r)*MK_W +: MK_W]     <= z_sel[MK_LO +: MK_W];
                           msgs_o[(N_ROUND-1-r)*MSG_W +: MSG_W]         <= z_sel[MSG_LO +: MSG_W];
                           C_o[(N_ROUND-1-r)*C_W +: C_W]                <= z_sel[C_LO +: C_W];
                           seed_lambda_o[(N_ROUND-1-r)*SL_W +: SL_W]    <= z_sel[SL_LO +: SL_W];
                           aux_triangle_o[(N_ROUND-1-r)*AUX_W +: AUX_W] <= z_sel[AUX_W-1:0];
                        end
                     end else if (c1 < C1_W'(N_SEED)) begin
                        seed_star_o[(N_ROUND-1-r)*128 +: 128] <= iseed_sel;
                        Cv_o[(N_ROUND-1-r)*256 +: 256]        <= cv_sel;
                     end
                  end
               end
               if (hit) c2 <= c2 + 1'b1;
               else     c1 <= c1 + 1'b1;
               if (j == J_W'(N_ROUND - 1)) state <= DONE;
               else                        j     <= j + 1'b1;
            end

            DONE: begin
               // End rises on entry; it drops only once start has been seen low.
               if (!parse_sign_end) begin
                  parse_sign_end <= 1'b1;
               end else if (!parse_sign_start) begin
                  parse_sign_end <= 1'b0;
                  state          <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parse_sign.sv
// Directed bench for parse_sign: table of lc vectors against a bench-side signature packer.
module tb_parse_sign;

   localparam int N_ROUND = 8;
   localparam int N_CHAL  = 4;
   localparam int Z_W     = 4352;
   localparam int SIG_W   = 19584;
   localparam int LC_W    = N_CHAL * 5;
   localparam int WIDE    = 1920 * N_ROUND;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    parse_sign_start;
   logic [LC_W-1:0]         lc;
   logic [SIG_W-1:0]        sigma_i;
   logic [255:0]            h_t_o, salt_o;
   logic [127:0]            seed_triangle_o;
   logic [128*N_ROUND-1:0]  seed_star_o, masked_key_o;
   logic [256*N_ROUND-1:0]  Cv_o, C_o;
   logic [1920*N_ROUND-1:0] seed_o;
   logic [512*N_ROUND-1:0]  msgs_o, seed_lambda_o;
   logic [1024*N_ROUND-1:0] aux_triangle_o;
   logic [N_ROUND-1:0]      in_lc_o;
   logic                    parse_err, parse_sign_end;

   parse_sign #(.N_ROUND(N_ROUND), .N_CHAL(N_CHAL)) dut (
      .clk(clk), .reset(reset), .parse_sign_start(parse_sign_start), .lc(lc), .sigma_i(sigma_i),
      .h_t_o(h_t_o), .salt_o(salt_o), .seed_triangle_o(seed_triangle_o),
      .seed_star_o(seed_star_o), .Cv_o(Cv_o), .seed_o(seed_o), .masked_key_o(masked_key_o),
      .msgs_o(msgs_o), .C_o(C_o), .seed_lambda_o(seed_lambda_o), .aux_triangle_o(aux_triangle_o),
      .in_lc_o(in_lc_o), .parse_err(parse_err), .parse_sign_end(parse_sign_end)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LC_W-1:0] lc;
      logic [7:0]      in_lc;
   } vec_t;

   vec_t vecs[4];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [127:0]            r_star[8];
   logic [255:0]            r_cv[8];
   logic [Z_W-1:0]          r_z[8];
   logic [255:0]            r_ht, r_salt;
   logic [127:0]            r_tri;

   logic [128*N_ROUND-1:0]  e_star, e_mk;
   logic [256*N_ROUND-1:0]  e_cv, e_c;
   logic [1920*N_ROUND-1:0] e_seed;
   logic [512*N_ROUND-1:0]  e_msgs, e_sl;
   logic [1024*N_ROUND-1:0] e_aux;

   task automatic check(input string name, input logic [WIDE-1:0] act, input logic [WIDE-1:0] exp);
      int first;
      n_checks++;
      if (act !== exp) begin
         first = -1;
         for (int b = WIDE - 1; b >= 0; b--) if (act[b] !== exp[b]) first = b;
         n_errors++;
         $display("FAIL %s: actual low64=%h required low64=%h (first differing bit %0d)",
                  name, act[63:0], exp[63:0], first);
      end
   endtask

   function automatic logic [Z_W-1:0] rnd();
      logic [Z_W-1:0] v;
      for (int i = 0; i < Z_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic new_data();
      logic [Z_W-1:0] t;
      t = rnd(); r_ht  = t[255:0];
      t = rnd(); r_salt = t[255:0];
      t = rnd(); r_tri = t[127:0];
      for (int j = 0; j < 8; j++) begin
         t = rnd(); r_star[j] = t[127:0];
         t = rnd(); r_cv[j]   = t[255:0];
         r_z[j] = rnd();
      end
   endtask

   // Signature packer: non-challenged rounds in order feed iSeedInfo/cvInfo, challenged rounds feed Z.
   task automatic make_sigma(input logic [7:0] mask);
      int pos;
      pos = SIG_W - 1;
      sigma_i[pos -: 256] = r_ht;   pos -= 256;
      sigma_i[pos -: 256] = r_salt; pos -= 256;
      for (int j = 0; j < 8; j++) if (!mask[7-j]) begin sigma_i[pos -: 128] = r_star[j]; pos -= 128; end
      for (int j = 0; j < 8; j++) if (!mask[7-j]) begin sigma_i[pos -: 256] = r_cv[j];   pos -= 256; end
      for (int j = 0; j < 8; j++) if (mask[7-j])  begin sigma_i[pos -: Z_W] = r_z[j];    pos -= Z_W; end
      sigma_i[127:0] = r_tri;
   endtask

   task automatic build_expected(input logic [7:0] mask);
      logic [Z_W-1:0] z;
      e_star = '0; e_cv = '0; e_seed = '0; e_mk = '0; e_msgs = '0; e_c = '0; e_sl = '0; e_aux = '0;
      for (int j = 0; j < 8; j++) begin
         z = r_z[j];
         if (mask[7-j]) begin
            e_seed[(7-j)*1920 +: 1920] = z[4351:2432];
            e_mk[(7-j)*128 +: 128]     = z[2431:2304];
            e_msgs[(7-j)*512 +: 512]   = z[2303:1792];
            e_c[(7-j)*256 +: 256]      = z[1791:1536];
            e_sl[(7-j)*512 +: 512]     = z[1535:1024];
            e_aux[(7-j)*1024 +: 1024]  = z[1023:0];
         end else begin
            e_star[(7-j)*128 +: 128] = r_star[j];
            e_cv[(7-j)*256 +: 256]   = r_cv[j];
         end
      end
   endtask

   task automatic compare_all(input string tag, input logic [7:0] exp_in_lc, input logic exp_err);
      check($sformatf("%s.h_t", tag), h_t_o, r_ht);
      check($sformatf("%s.salt", tag), salt_o, r_salt);
      check($sformatf("%s.seed_tri", tag), seed_triangle_o, r_tri);
      check($sformatf("%s.in_lc", tag), in_lc_o, exp_in_lc);
      check($sformatf("%s.err", tag), parse_err, exp_err);
      check($sformatf("%s.seed_star", tag), seed_star_o, e_star);
      check($sformatf("%s.Cv", tag), Cv_o, e_cv);
      check($sformatf("%s.seed", tag), seed_o, e_seed);
      check($sformatf("%s.masked_key", tag), masked_key_o, e_mk);
      check($sformatf("%s.msgs", tag), msgs_o, e_msgs);
      check($sformatf("%s.C", tag), C_o, e_c);
      check($sformatf("%s.seed_lambda", tag), seed_lambda_o, e_sl);
      check($sformatf("%s.aux", tag), aux_triangle_o, e_aux);
   endtask

   task automatic check_zero(input string tag);
      check($sformatf("%s.h_t0", tag), h_t_o, '0);
      check($sformatf("%s.salt0", tag), salt_o, '0);
      check($sformatf("%s.tri0", tag), seed_triangle_o, '0);
      check($sformatf("%s.star0", tag), seed_star_o, '0);
      check($sformatf("%s.Cv0", tag), Cv_o, '0);
      check($sformatf("%s.seed0", tag), seed_o, '0);
      check($sformatf("%s.mk0", tag), masked_key_o, '0);
      check($sformatf("%s.msgs0", tag), msgs_o, '0);
      check($sformatf("%s.C0", tag), C_o, '0);
      check($sformatf("%s.sl0", tag), seed_lambda_o, '0);
      check($sformatf("%s.aux0", tag), aux_triangle_o, '0);
      check($sformatf("%s.in_lc0", tag), in_lc_o, '0);
      check($sformatf("%s.err0", tag), parse_err, 1'b0);
      check($sformatf("%s.end0", tag), parse_sign_end, 1'b0);
   endtask

   // Called just after inputs are driven at a negedge; the next posedge is edge 0.
   task automatic wait_end(output int lat);
      lat = -1;
      @(posedge clk);
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (parse_sign_end && lat < 0) lat = e;
         if (lat >= 0) break;
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      new_data();
      make_sigma(v.in_lc);
      build_expected(v.in_lc);
      @(negedge clk);
      lc = v.lc;
      parse_sign_start = 1'b1;
      wait_end(lat);
      check($sformatf("%s.latency", tag), lat, 10);
      compare_all(tag, v.in_lc, 1'b0);
   endtask

   task automatic drop_start(input string tag);
      @(negedge clk);
      parse_sign_start = 1'b0;
      @(negedge clk);
      check($sformatf("%s.end_fall", tag), parse_sign_end, 1'b0);
   endtask

   initial begin
      int lat;
      vecs[0] = '{lc: {5'd1, 5'd3, 5'd5, 5'd7}, in_lc: 8'b01010101};
      vecs[1] = '{lc: {5'd0, 5'd1, 5'd2, 5'd3}, in_lc: 8'b11110000};
      vecs[2] = '{lc: {5'd6, 5'd2, 5'd4, 5'd0}, in_lc: 8'b10101010};
      vecs[3] = '{lc: {5'd7, 5'd0, 5'd3, 5'd4}, in_lc: 8'b10011001};

      reset = 1'b1;
      parse_sign_start = 1'b0;
      lc = '0;
      sigma_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
         drop_start($sformatf("vec%0d", i));
      end

      // Start held past end: no retrigger, captured data immune to input changes.
      run_vec("hold", vecs[0]);
      sigma_i = ~sigma_i;
      lc = {5'd0, 5'd1, 5'd2, 5'd3};
      repeat (5) @(posedge clk);
      #1;
      check("hold.end_held", parse_sign_end, 1'b1);
      compare_all("hold.stable", vecs[0].in_lc, 1'b0);
      drop_start("hold");
      run_vec("restart", vecs[2]);
      drop_start("restart");

      // Start dropped mid-scan: scan completes and end pulses for one cycle.
      new_data();
      make_sigma(vecs[1].in_lc);
      build_expected(vecs[1].in_lc);
      @(negedge clk);
      lc = vecs[1].lc;
      parse_sign_start = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      parse_sign_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pulse.end_edge9", parse_sign_end, 1'b0);
      @(posedge clk); #1;
      check("pulse.end_edge10", parse_sign_end, 1'b1);
      compare_all("pulse", vecs[1].in_lc, 1'b0);
      @(posedge clk); #1;
      check("pulse.end_edge11", parse_sign_end, 1'b0);

      // Reset while round 4 is being scanned.
      new_data();
      make_sigma(vecs[3].in_lc);
      @(negedge clk);
      lc = vecs[3].lc;
      parse_sign_start = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      parse_sign_start = 1'b0;
      @(posedge clk); #1;
      check_zero("midrst");
      @(negedge clk);
      reset = 1'b0;
      run_vec("after_rst", vecs[3]);
      drop_start("after_rst");

`ifdef PARSE_SIGN_CHK_EN
      // Duplicate entry, then out-of-range entry: flagged, round arrays untouched.
      for (int t = 0; t < 2; t++) begin
         new_data();
         make_sigma(8'b00100011);
         e_star = '0; e_cv = '0; e_seed = '0; e_mk = '0; e_msgs = '0; e_c = '0; e_sl = '0; e_aux = '0;
         @(negedge clk);
         lc = (t == 0) ? {5'd2, 5'd2, 5'd5, 5'd6} : {5'd1, 5'd9, 5'd3, 5'd4};
         parse_sign_start = 1'b1;
         wait_end(lat);
         check($sformatf("bad%0d.end_early", t), (lat >= 1 && lat <= 3), 1'b1);
         compare_all($sformatf("bad%0d", t), 8'h00, 1'b1);
         drop_start($sformatf("bad%0d", t));
      end
`else
      // Trusted duplicate lc: rounds 2,5,6 challenged; fifth open round (7) finds no slot left.
      new_data();
      make_sigma(8'b00100111);
      build_expected(8'b00100111);
      e_seed[1919:0] = '0; e_mk[127:0] = '0; e_msgs[511:0] = '0;
      e_c[255:0] = '0; e_sl[511:0] = '0; e_aux[1023:0] = '0;
      @(negedge clk);
      lc = {5'd2, 5'd2, 5'd5, 5'd6};
      parse_sign_start = 1'b1;
      wait_end(lat);
      check("dup.latency", lat, 10);
      compare_all("dup", 8'b00100110, 1'b0);
      drop_start("dup");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
